note_decoder_poly: RTL and testbench

NOTE_DECODER_POLY -- requirements
Module: note_decoder_poly

---
 rtl/note_decoder_poly.sv | 93 +++++++++
 tb/tb_note_decoder_poly.sv | 102 ++++++++++
 2 files changed

// File: rtl/note_decoder_poly.sv
// note_decoder_poly: polyphonic square-wave tone mixer; define NOTE_DECODER_POLY_DECAY_EN for per-channel decaying envelopes
module note_decoder_poly #(
  parameter int CHANNELS  = 3,
  parameter int NOTE_W    = 9,
  parameter int OUT_W     = 8,
  parameter int PRESCALE  = 16,
  parameter int DECAY_DIV = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [CHANNELS*NOTE_W-1:0] note,
  output logic [OUT_W-1:0]           out,
  output logic [CHANNELS-1:0]        active
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [OUT_W-1:0] AMP = OUT_W'(((2 ** OUT_W) - 1) / CHANNELS);
  logic [PW-1:0]     r_pre;
  logic              w_tick;
  logic [NOTE_W-1:0] r_code [CHANNELS];
  logic [NOTE_W-1:0] r_cnt  [CHANNELS];
  logic [NOTE_W-1:0] w_new  [CHANNELS];
  logic [CHANNELS-1:0] r_phase, w_chg, w_wrap;
  logic [OUT_W-1:0]  w_sum;
`ifdef NOTE_DECODER_POLY_DECAY_EN
  localparam int DW = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
  logic [OUT_W-1:0] r_env [CHANNELS];
  logic [DW-1:0]    r_div;
  logic             w_dstep;
  assign w_dstep = r_div == DW'(DECAY_DIV - 1);
`else
  logic w_unused;
  assign w_unused = DECAY_DIV != 0;
`endif
  assign w_tick = r_pre == PW'(PRESCALE - 1);
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_new[i]  = note[i*NOTE_W +: NOTE_W];
      w_chg[i]  = load && (w_new[i] != r_code[i]);
      w_wrap[i] = r_cnt[i] == r_code[i] - NOTE_W'(1);
`ifdef NOTE_DECODER_POLY_DECAY_EN
      w_sum = w_sum + (r_phase[i] ? r_env[i] : '0);
`else
      w_sum = w_sum + (r_phase[i] ? AMP : '0);
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      out     <= '0;
      active  <= '0;
      r_phase <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_code[i] <= '0;
        r_cnt[i]  <= '0;
`ifdef NOTE_DECODER_POLY_DECAY_EN
        r_env[i]  <= '0;
`endif
      end
`ifdef NOTE_DECODER_POLY_DECAY_EN
      r_div <= '0;
`endif
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      out   <= w_sum;
`ifdef NOTE_DECODER_POLY_DECAY_EN
      r_div <= w_dstep ? '0 : r_div + DW'(1);
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        if (load) begin
          r_code[i] <= w_new[i];
          active[i] <= |w_new[i];
        end
        // a changed code restarts its channel; an idle channel stays parked at zero
        if (w_chg[i] || r_code[i] == '0) begin
          r_cnt[i]   <= '0;
          r_phase[i] <= 1'b0;
        end else if (w_tick) begin
          r_cnt[i]   <= w_wrap[i] ? '0 : r_cnt[i] + NOTE_W'(1);
          r_phase[i] <= r_phase[i] ^ w_wrap[i];
        end
`ifdef NOTE_DECODER_POLY_DECAY_EN
        if (w_chg[i])
          r_env[i] <= w_new[i] != '0 ? AMP : '0;
        else if (w_dstep && r_env[i] != '0)
          r_env[i] <= r_env[i] - OUT_W'(1);
`endif
      end
    end
  end
endmodule

// File: tb/tb_note_decoder_poly.sv
// tb_note_decoder_poly: directed plus random stimulus against a tick-count tone model
module tb_note_decoder_poly;
  logic        clk = 1'b0;
  logic        rst, load;
  logic [26:0] note;
  logic [7:0]  out;
  logic [2:0]  active;
  int tests = 0, fails = 0;
  int m_code[3], m_n[3], m_ph[3], m_e, m_out;
  bit saw255 = 0;

  note_decoder_poly dut (.clk(clk), .rst(rst), .load(load), .note(note), .out(out), .active(active));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] pack(input int c2, input int c1, input int c0);
    return {9'(c2), 9'(c1), 9'(c0)};
  endfunction

  // model: phase of a sounding channel is floor(ticks since restart / code) mod 2
  task automatic step(input logic r, input logic l, input logic [26:0] n);
    logic [2:0] exp_act;
    bit tick;
    int c;
    rst = r; load = l; note = n;
    @(posedge clk);
    if (r) begin
      m_e = 0; m_out = 0;
      for (int i = 0; i < 3; i++) begin m_code[i] = 0; m_n[i] = 0; m_ph[i] = 0; end
    end else begin
      m_out = 85 * (m_ph[0] + m_ph[1] + m_ph[2]);
      tick = (m_e % 16) == 15;
      m_e++;
      for (int i = 0; i < 3; i++) begin
        c = int'(n[i*9 +: 9]);
        if (l && c != m_code[i]) begin m_code[i] = c; m_n[i] = 0; end
        else if (m_code[i] != 0 && tick) m_n[i]++;
        m_ph[i] = m_code[i] == 0 ? 0 : (m_n[i] / m_code[i]) % 2;
      end
    end
    for (int i = 0; i < 3; i++) exp_act[i] = m_code[i] != 0;
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("active", 32'(active), 32'(exp_act));
    if (out == 8'd255) saw255 = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 27'($urandom));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; note = '0;
    @(negedge clk);
    step(1'b1, 1'b1, 27'($urandom));
    step(1'b1, 1'b1, 27'($urandom));
    // single channel, code 1: 32-cycle period at amplitude 85
    step(1'b0, 1'b1, 27'h0000001);
    idle(80);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 27'h0000001);
    // three channels, all phases eventually align high
    step(1'b0, 1'b1, pack(4, 3, 2));
    saw255 = 0;
    idle(400);
    chk("reach255", 32'(saw255), 32'd1);
    // ch0 and ch2 unchanged, ch1 restarted mid-period
    idle(37);
    step(1'b0, 1'b1, pack(4, 5, 2));
    idle(200);
    // all codes cleared
    step(1'b0, 1'b1, 27'h0);
    idle(5);
    // reset after activity
    step(1'b0, 1'b1, pack(1, 2, 3));
    idle(53);
    step(1'b1, 1'b1, pack(6, 6, 6));
    step(1'b1, 1'b0, 27'h0);
    idle(40);
    // random loads with partial channel changes and occasional reset
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) step(1'b1, 1'($urandom), 27'($urandom));
      else if ($urandom_range(0, 19) == 0) begin
        logic [26:0] n;
        n = {9'(m_code[2]), 9'(m_code[1]), 9'(m_code[0])};
        for (int i = 0; i < 3; i++)
          if ($urandom_range(0, 1) == 1) n[i*9 +: 9] = 9'($urandom_range(0, 5));
        step(1'b0, 1'b1, n);
      end else step(1'b0, 1'b0, 27'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
